// File: rtl/result_writeback_unit_pkg.sv
// Shared definitions for the result writeback sequencer: FSM encoding, flag bit positions,
// default widths and an index-width helper.
package result_writeback_unit_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrive   = 2'd1,
    StCapture = 2'd2
  } wb_state_e;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;

  localparam int unsigned DefaultDataW    = 8;
  localparam int unsigned DefaultFlagW    = 4;
  localparam int unsigned DefaultNumUnits = 4;
  localparam int unsigned DefaultNumRegs  = 4;

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// Writeback register file: one synchronous write port, one combinational read port,
// asynchronous clear.
module wb_regfile
  import result_writeback_unit_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  localparam int unsigned AddrW   = idx_w(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AddrW-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AddrW-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: a read of the address being written returns the old value.
  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/result_writeback_unit.sv
// Sequences one tri-state functional unit onto the result/flag buses per request and writes
// the sampled values back into the register file and status register.
module result_writeback_unit
  import result_writeback_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned FLAG_W    = DefaultFlagW,
  parameter int unsigned NUM_UNITS = DefaultNumUnits,
  parameter int unsigned NUM_REGS  = DefaultNumRegs,
  localparam int unsigned UnitW    = idx_w(NUM_UNITS),
  localparam int unsigned RegW     = idx_w(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [UnitW-1:0]     req_unit,
  input  logic [RegW-1:0]      req_dest,
  input  logic                 req_flag_we,
  output logic [NUM_UNITS-1:0] unit_oe,
  input  logic [DATA_W-1:0]    result_bus,
  input  logic [FLAG_W-1:0]    flags_bus,
  input  logic [RegW-1:0]      rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [FLAG_W-1:0]    status_flags,
  output logic                 done,
  output logic                 error
);

  wb_state_e            state_q, state_d;
  logic [RegW-1:0]      dest_q, dest_d;
  logic                 flag_we_q, flag_we_d;
  logic                 unit_ok_q, unit_ok_d;
  logic [NUM_UNITS-1:0] unit_oe_q, unit_oe_d;
  logic [FLAG_W-1:0]    status_q, status_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 reg_we;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    flag_we_d = flag_we_q;
    unit_ok_d = unit_ok_q;
    unit_oe_d = unit_oe_q;
    status_d  = status_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    reg_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        unit_oe_d = '0;
        if (req_valid) begin
          dest_d    = req_dest;
          flag_we_d = req_flag_we;
          unit_ok_d = 32'(req_unit) < NUM_UNITS;
          // Out-of-range index matches no bit, so an invalid unit is never enabled.
          for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            unit_oe_d[i] = (32'(req_unit) == i);
          end
          state_d = StDrive;
        end
      end
      StDrive: state_d = StCapture;
      StCapture: begin
        state_d   = StIdle;
        unit_oe_d = '0;
        done_d    = 1'b1;
        error_d   = !unit_ok_q;
        reg_we    = unit_ok_q;
        if (unit_ok_q && flag_we_q) status_d = flags_bus;
      end
      default: begin
        state_d   = StIdle;
        unit_oe_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      dest_q    <= '0;
      flag_we_q <= 1'b0;
      unit_ok_q <= 1'b0;
      unit_oe_q <= '0;
      status_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      flag_we_q <= flag_we_d;
      unit_ok_q <= unit_ok_d;
      unit_oe_q <= unit_oe_d;
      status_q  <= status_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  wb_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk_i  (clock),
    .rst_ni (nreset),
    .we_i   (reg_we),
    .waddr_i(dest_q),
    .wdata_i(result_bus),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign req_ready    = (state_q == StIdle);
  assign unit_oe      = unit_oe_q;
  assign status_flags = status_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_result_writeback_unit.sv
// Directed bench for result_writeback_unit: a 4-unit instance for the main sequences and a
// 3-unit instance for the out-of-range unit case.
module tb_result_writeback_unit;

  logic       clock = 1'b0;
  logic       nreset;
  logic       req_valid, req_valid3;
  logic [1:0] req_unit, req_dest, rd_addr;
  logic       req_flag_we;
  logic [7:0] result_bus;
  logic [3:0] flags_bus;

  logic       req_ready, done, error;
  logic [3:0] unit_oe, status_flags;
  logic [7:0] rd_data;

  logic       req_ready3, done3, error3;
  logic [2:0] unit_oe3;
  logic [3:0] status_flags3;
  logic [7:0] rd_data3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  result_writeback_unit dut (
    .clock(clock), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_unit(req_unit), .req_dest(req_dest), .req_flag_we(req_flag_we), .unit_oe(unit_oe),
    .result_bus(result_bus), .flags_bus(flags_bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .status_flags(status_flags), .done(done), .error(error)
  );

  result_writeback_unit #(.NUM_UNITS(3)) dut3 (
    .clock(clock), .nreset(nreset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_unit(req_unit), .req_dest(req_dest), .req_flag_we(req_flag_we), .unit_oe(unit_oe3),
    .result_bus(result_bus), .flags_bus(flags_bus), .rd_addr(rd_addr), .rd_data(rd_data3),
    .status_flags(status_flags3), .done(done3), .error(error3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] unit, input logic [1:0] dest, input logic fwe,
                       input logic [7:0] res, input logic [3:0] flg);
    req_unit    = unit;
    req_dest    = dest;
    req_flag_we = fwe;
    result_bus  = res;
    flags_bus   = flg;
  endtask

  logic [7:0] b2b_res  [3] = '{8'h21, 8'h43, 8'h65};
  logic [1:0] b2b_unit [3] = '{2'd0, 2'd2, 2'd3};
  logic [1:0] b2b_dest [3] = '{2'd1, 2'd3, 2'd2};

  initial begin
    nreset = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; rd_addr = 2'd0;
    issue(2'd0, 2'd0, 1'b0, 8'h00, 4'h0);
    #12 nreset = 1'b1;
    tick();
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_oe", unit_oe, 0);
    check_eq("rst_status", status_flags, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd0", rd_data, 0);

    // Basic writeback
    rd_addr = 2'd2;
    issue(2'd1, 2'd2, 1'b1, 8'hA5, 4'b0010);
    req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    check_eq("basic_oe_drive", unit_oe, 4'b0010);
    check_eq("basic_ready_drive", req_ready, 0);
    check_eq("basic_done_drive", done, 0);
    tick();
    check_eq("basic_oe_capture", unit_oe, 4'b0010);
    check_eq("basic_rd_old", rd_data, 0);
    tick();
    check_eq("basic_oe_idle", unit_oe, 0);
    check_eq("basic_rd_new", rd_data, 8'hA5);
    check_eq("basic_status", status_flags, 4'b0010);
    check_eq("basic_done", done, 1);
    check_eq("basic_error", error, 0);
    check_eq("basic_ready_idle", req_ready, 1);
    tick();
    check_eq("basic_done_once", done, 0);

    // Preload status, then write with flag_we=0
    rd_addr = 2'd0;
    issue(2'd0, 2'd0, 1'b1, 8'h00, 4'b0001);
    req_valid = 1'b1; tick(); req_valid = 1'b0; tick(); tick();
    check_eq("fwe_preload_status", status_flags, 4'b0001);
    issue(2'd0, 2'd0, 1'b0, 8'h3C, 4'b0010);
    req_valid = 1'b1; tick(); req_valid = 1'b0; tick(); tick();
    check_eq("fwe_rd0", rd_data, 8'h3C);
    check_eq("fwe_status_kept", status_flags, 4'b0001);

    // Back-to-back with req_valid held high
    req_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      issue(b2b_unit[r], b2b_dest[r], 1'b0, b2b_res[r], 4'b0100);
      tick();
      check_eq($sformatf("b2b%0d_oe_drive", r), unit_oe, 32'(4'b0001 << b2b_unit[r]));
      check_eq($sformatf("b2b%0d_ready_drive", r), req_ready, 0);
      tick();
      check_eq($sformatf("b2b%0d_oe_capture", r), unit_oe, 32'(4'b0001 << b2b_unit[r]));
      tick();
      check_eq($sformatf("b2b%0d_oe_gap", r), unit_oe, 0);
      check_eq($sformatf("b2b%0d_done", r), done, 1);
      check_eq($sformatf("b2b%0d_ready_idle", r), req_ready, 1);
    end
    req_valid = 1'b0;
    tick();
    check_eq("b2b_no_extra_accept", req_ready, 1);
    rd_addr = 2'd1; #1 check_eq("b2b_rd1", rd_data, 8'h21);
    rd_addr = 2'd3; #1 check_eq("b2b_rd3", rd_data, 8'h43);
    rd_addr = 2'd2; #1 check_eq("b2b_rd2", rd_data, 8'h65);
    check_eq("b2b_status", status_flags, 4'b0001);

    // Invalid unit on the 3-unit instance
    rd_addr = 2'd0;
    issue(2'd3, 2'd0, 1'b1, 8'hFF, 4'b1111);
    req_valid3 = 1'b1; tick(); req_valid3 = 1'b0;
    check_eq("inv_oe_drive", unit_oe3, 0);
    check_eq("inv_ready_drive", req_ready3, 0);
    tick();
    check_eq("inv_oe_capture", unit_oe3, 0);
    tick();
    check_eq("inv_done", done3, 1);
    check_eq("inv_error", error3, 1);
    check_eq("inv_rd0", rd_data3, 0);
    check_eq("inv_status", status_flags3, 0);
    tick();
    check_eq("inv_done_once", done3, 0);
    check_eq("inv_error_once", error3, 0);

    // Read hazard: no bypass during CAPTURE
    rd_addr = 2'd1;
    issue(2'd2, 2'd1, 1'b0, 8'h7F, 4'b0000);
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    tick();
    check_eq("haz_rd_capture", rd_data, 8'h21);
    tick();
    check_eq("haz_rd_after", rd_data, 8'h7F);

    // Asynchronous reset in the middle of CAPTURE
    rd_addr = 2'd3;
    issue(2'd1, 2'd3, 1'b1, 8'h55, 4'b1000);
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    tick();
    check_eq("rstmid_oe_capture", unit_oe, 4'b0010);
    #2 nreset = 1'b0;
    #1;
    check_eq("rstmid_oe", unit_oe, 0);
    check_eq("rstmid_rd3", rd_data, 0);
    check_eq("rstmid_status", status_flags, 0);
    check_eq("rstmid_done", done, 0);
    #2 nreset = 1'b1;
    tick();
    check_eq("rstmid_ready", req_ready, 1);
    check_eq("rstmid_oe_after", unit_oe, 0);
    check_eq("rstmid_rd3_after", rd_data, 0);
    check_eq("rstmid_done_after", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
